// File: rtl/led_frame_pkg.sv
// Shared types and constants for the double-buffered LED frame controller.
// Pixel layout is 24-bit RGB: red in the top byte, blue in the bottom byte.
package led_frame_pkg;

  localparam int PIXEL_W   = 24;
  localparam int CHAN_W    = 8;
  localparam int RED_LSB   = 16;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_VSYNC = 2'd1,
    COPY       = 2'd2
  } state_t;

  function automatic logic [PIXEL_W-1:0] pixel_rgb(input logic [CHAN_W-1:0] r,
                                                    input logic [CHAN_W-1:0] g,
                                                    input logic [CHAN_W-1:0] b);
    logic [PIXEL_W-1:0] p;
    p = '0;
    p[RED_LSB   +: CHAN_W] = r;
    p[GREEN_LSB +: CHAN_W] = g;
    p[BLUE_LSB  +: CHAN_W] = b;
    return p;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. When both requesters are valid, prio_b picks the winner.
// On each advance, priority passes to whichever requester was not granted.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic advance,
  output logic grant_a,
  output logic grant_b
);

  logic prio_b;

  assign grant_a = req_a && (!req_b || !prio_b);
  assign grant_b = req_b && (!req_a || prio_b);

  // NOTE: sequential state uses non-blocking assignments, so every register reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_b <= 1'b0;
    end else if (advance) begin
      prio_b <= grant_a;
    end
  end

endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered LED frame controller. Pixel writes go to the back buffer, and a commit swaps the buffers on the next vsync.
// After the swap, the new front buffer is copied back so that later edits start from the displayed frame.
module led_frame_ctrl
  import led_frame_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_valid,
  input  logic [ADDR_W-1:0]           a_addr,
  input  logic [PIXEL_W-1:0]          a_data,
  output logic                        a_ready,
  input  logic                        b_valid,
  input  logic [ADDR_W-1:0]           b_addr,
  input  logic [PIXEL_W-1:0]          b_data,
  output logic                        b_ready,
  input  logic                        commit_valid,
  output logic                        commit_ready,
  input  logic                        vsync,
  output logic                        swapped,
  output logic                        busy,
  output logic [PIXEL_W*NUM_LEDS-1:0] values
);

  localparam int                  DEPTH    = 2 ** ADDR_W;
  localparam logic [DEPTH-1:0]    ADDR_OK  = {DEPTH{1'b1}} >> (DEPTH - NUM_LEDS);
  localparam logic [ADDR_W-1:0]   LAST_IDX = ADDR_W'(NUM_LEDS - 1);

  state_t              state;
  logic                front_sel;
  logic                back_sel;
  logic [ADDR_W-1:0]   copy_idx;
  logic [PIXEL_W-1:0]  fb [2][NUM_LEDS];

  logic                grant_a;
  logic                grant_b;
  logic                pixel_open;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PIXEL_W-1:0]  wr_data;

  assign back_sel     = ~front_sel;
  assign pixel_open   = (state == IDLE) && !commit_valid;
  assign a_ready      = pixel_open && grant_a;
  assign b_ready      = pixel_open && grant_b;
  assign commit_ready = (state == IDLE) && commit_valid;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (a_valid),
    .req_b   (b_valid),
    .advance (a_ready || b_ready),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  // Out-of-range addresses still complete the handshake. Only the store is suppressed.
  always_comb begin
    wr_addr = a_ready ? a_addr : b_addr;
    wr_data = a_ready ? a_data : b_data;
    wr_en   = (a_ready && ADDR_OK[a_addr]) || (b_ready && ADDR_OK[b_addr]);
  end

  // NOTE: the frame buffers are reset on purpose because the displayed frame must read as black out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          fb[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      fb[back_sel][wr_addr] <= wr_data;
    end else if (state == COPY) begin
      fb[back_sel][copy_idx] <= fb[front_sel][copy_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      copy_idx  <= '0;
      swapped   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      swapped <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_valid) begin
            state <= WAIT_VSYNC;
            busy  <= 1'b1;
          end
        end
        WAIT_VSYNC: begin
          if (vsync) begin
            front_sel <= ~front_sel;
            copy_idx  <= '0;
            swapped   <= 1'b1;
            state     <= COPY;
          end
        end
        COPY: begin
          copy_idx <= copy_idx + 1'b1;
          if (copy_idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_values
    assign values[PIXEL_W*i +: PIXEL_W] = fb[front_sel][i];
  end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Self-checking bench for led_frame_ctrl. It combines directed steps and random traffic.
// Results are compared against an array-level model of the front and back frames.
module tb_led_frame_ctrl;
  import led_frame_pkg::*;

  localparam int N  = 16;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid, commit_valid, vsync;
  logic [AW-1:0]    a_addr, b_addr;
  logic [23:0]      a_data, b_data;
  logic             a_ready, b_ready, commit_ready, swapped, busy;
  logic [24*N-1:0]  values;

  int errors = 0;
  int checks = 0;

  // Reference model: whole frames as arrays, plus a phase marker (0 idle, 1 waiting, 2 copying).
  logic [23:0] m_front [N];
  logic [23:0] m_back  [N];
  int          m_phase;
  int          m_copy_left;
  bit          m_prio_b;
  bit          m_swapped;

  led_frame_ctrl #(.NUM_LEDS(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .vsync        (vsync),
    .swapped      (swapped),
    .busy         (busy),
    .values       (values)
  );

  always #5 clk = ~clk;

  function automatic logic [24*N-1:0] model_values();
    logic [24*N-1:0] v;
    for (int i = 0; i < N; i++) v[24*i +: 24] = m_front[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [24*N-1:0] obs, input logic [24*N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    m_phase     = 0;
    m_copy_left = 0;
    m_prio_b    = 1'b0;
    m_swapped   = 1'b0;
  endtask

  task automatic model_store(input logic [AW-1:0] addr, input logic [23:0] data);
    int ai;
    ai = addr;
    if (ai < N) m_back[ai] = data;
  endtask

  // Run one clock cycle. Inputs must already be driven. The task checks the handshakes before the edge and the registered outputs after it.
  task automatic tick();
    bit idle, ea, eb, ec;
    logic [23:0] tmp [N];
    idle = (m_phase == 0);
    ec   = idle && commit_valid;
    ea   = idle && !commit_valid && a_valid && (!b_valid || !m_prio_b);
    eb   = idle && !commit_valid && b_valid && (!a_valid || m_prio_b);
    #1;
    if (!rst) begin
      check("a_ready", a_ready, ea);
      check("b_ready", b_ready, eb);
      check("commit_ready", commit_ready, ec);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_swapped = 1'b0;
      if (ea) begin
        model_store(a_addr, a_data);
        m_prio_b = 1'b1;
      end else if (eb) begin
        model_store(b_addr, b_data);
        m_prio_b = 1'b0;
      end
      if (ec) begin
        m_phase = 1;
      end else if (m_phase == 1 && vsync) begin
        tmp = m_front;
        m_front = m_back;
        m_back = tmp;
        m_phase = 2;
        m_copy_left = N;
        m_swapped = 1'b1;
      end else if (m_phase == 2) begin
        m_copy_left--;
        if (m_copy_left == 0) begin
          m_back = m_front;
          m_phase = 0;
        end
      end
    end
    #1;
    check("values", values, model_values());
    check("busy", busy, m_phase != 0);
    check("swapped", swapped, m_swapped);
    @(negedge clk);
  endtask

  task automatic quiet();
    a_valid = 1'b0; b_valid = 1'b0; commit_valid = 1'b0; vsync = 1'b0;
  endtask

  task automatic rand_pixels();
    a_valid = 1'($urandom);
    b_valid = 1'($urandom);
    a_addr  = AW'($urandom);
    b_addr  = AW'($urandom);
    a_data  = 24'($urandom);
    b_data  = 24'($urandom);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    quiet();
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_values", values, '0);

    // A write lands in the back buffer only.
    a_valid = 1'b1; a_addr = 4'd3; a_data = pixel_rgb(8'hFF, 8'h00, 8'h00);
    tick();
    quiet();
    check("write_isolation", values, '0);

    // Commit, then vsync five cycles later, with pixel traffic stalled through the copy.
    commit_valid = 1'b1;
    tick();
    quiet();
    repeat (4) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("swap_pix3", values[95:72], 24'hFF0000);
    repeat (N) begin
      rand_pixels();
      tick();
    end
    quiet();
    tick();
    check("copy_done_idle", busy, 1'b0);

    // Copy-back: edit pixel 0 via B, commit, swap after a random delay.
    b_valid = 1'b1; b_addr = 4'd0; b_data = pixel_rgb(8'h00, 8'hFF, 8'h00);
    tick();
    quiet();
    commit_valid = 1'b1;
    tick();
    quiet();
    repeat ($urandom_range(1, 6)) tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    check("copyback_pix0", values[23:0], 24'h00FF00);
    check("copyback_pix3", values[95:72], 24'hFF0000);
    repeat (N) tick();

    // Both requesters held: grants alternate, beginning with the current priority holder.
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (4) begin
      a_addr = AW'($urandom); b_addr = AW'($urandom);
      a_data = 24'($urandom); b_data = 24'($urandom);
      tick();
    end

    // Commit outranks both pixel requesters, then reset lands mid-copy.
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    tick();
    quiet();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (5) begin
      rand_pixels();
      tick();
    end
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_values", values, '0);
    check("abort_busy", busy, 1'b0);
    tick();

    // Random traffic, including stray vsyncs and commits.
    repeat (400) begin
      rand_pixels();
      commit_valid = ($urandom_range(0, 11) == 0);
      vsync        = ($urandom_range(0, 5) == 0);
      tick();
    end
    quiet();
    repeat (N + 4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
